pipe_stage_buf: RTL and testbench

//  Parametrised pipeline-stage register with a ready/valid handshake and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_sat_counter.sv | 33 +++
 rtl/pipe_stage_buf.sv | 132 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared state encoding and defaults for pipe_stage_buf
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int   DEF_DATA_W     = 64;
  // Bubble defaults to all-zero payload; replicated to the configured width
  localparam logic DEF_BUBBLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// ============================================================================
// pipe_sat_counter : up-counter that saturates at all-ones instead of wrapping
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (inc_i && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule : pipe_sat_counter

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : pipeline-stage register, ready/valid with 2-entry skid buffer
//                  Optional statistics counters enabled by macro PIPE_STAT_EN.
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{DEF_BUBBLE_BIT}}
`ifdef PIPE_STAT_EN
  ,
  parameter int                 CNT_W      = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  pipe_state_e       r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_out_valid;
  logic              r_in_ready;

  logic              w_push;
  logic              w_pop;

  assign w_push = in_valid_i  & r_in_ready;
  assign w_pop  = r_out_valid & out_ready_i;

  // Handshake flags are kept as their own flops so neither ready nor valid
  // ever depends combinationally on the opposite side's input.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_EMPTY;
      r_main      <= BUBBLE_VAL;
      r_skid      <= BUBBLE_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush_i) begin
      r_state     <= ST_EMPTY;
      r_main      <= BUBBLE_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_main      <= in_data_i;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_main <= in_data_i;
          end else if (w_push) begin
            r_skid     <= in_data_i;
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_main      <= BUBBLE_VAL;
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main      <= BUBBLE_VAL;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main;

`ifdef PIPE_STAT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = r_out_valid & ~out_ready_i;
  // Only flushes that actually discard something are counted
  assign w_flush_inc = flush_i & (r_state != ST_EMPTY);

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_stall_inc),
    .count_o (stall_cnt_o)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_flush_inc),
    .count_o (flush_cnt_o)
  );
`endif

endmodule : pipe_stage_buf

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// tb_pipe_stage_buf : directed self-checking bench for pipe_stage_buf
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buf;

  localparam int          DW  = 16;
  localparam logic [15:0] BUB = 16'h0013;
`ifdef PIPE_STAT_EN
  localparam int          CW  = 4;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
`ifdef PIPE_STAT_EN
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_buf #(
    .DATA_W     (DW),
    .BUBBLE_VAL (BUB)
`ifdef PIPE_STAT_EN
    ,
    .CNT_W      (CW)
`endif
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;

    // Power-on reset
    #2 rst_i = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_data",  {16'd0, out_data_o},  {16'd0, BUB});
    chk("rst_ready", {31'd0, in_ready_o},  32'd1);
`ifdef PIPE_STAT_EN
    chk("rst_stall", {28'd0, stall_cnt_o}, 32'd0);
    chk("rst_flush", {28'd0, flush_cnt_o}, 32'd0);
`endif
    #4 rst_i = 1'b1;

    // Streaming: 1-cycle latency, one transfer per cycle
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data_i = DW'(i);
      tick();
      chk("stream_valid", {31'd0, out_valid_o}, 32'd1);
      chk("stream_data",  {16'd0, out_data_o},  32'(i));
      chk("stream_ready", {31'd0, in_ready_o},  32'd1);
    end
    in_valid_i = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid_o}, 32'd0);
    chk("drain_data",  {16'd0, out_data_o},  {16'd0, BUB});

    // Backpressure fills skid
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h000A;
    tick();
    chk("bp_a_data",  {16'd0, out_data_o}, 32'h000A);
    chk("bp_a_ready", {31'd0, in_ready_o}, 32'd1);
    in_data_i = 16'h000B;
    tick();
    chk("bp_b_ready", {31'd0, in_ready_o}, 32'd0);
    chk("bp_b_data",  {16'd0, out_data_o}, 32'h000A);
    in_valid_i = 1'b0;
    tick();
    chk("bp_hold_data",  {16'd0, out_data_o}, 32'h000A);
    chk("bp_hold_ready", {31'd0, in_ready_o}, 32'd0);
    out_ready_i = 1'b1;
    tick();
    chk("bp_rel_valid", {31'd0, out_valid_o}, 32'd1);
    chk("bp_rel_data",  {16'd0, out_data_o},  32'h000B);
    chk("bp_rel_ready", {31'd0, in_ready_o},  32'd1);
    tick();
    chk("bp_end_valid", {31'd0, out_valid_o}, 32'd0);
    chk("bp_end_data",  {16'd0, out_data_o},  {16'd0, BUB});
`ifdef PIPE_STAT_EN
    chk("bp_stall", {28'd0, stall_cnt_o}, 32'd2);
`endif

    // Flush while TWO with simultaneous push of 0xC
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0021;
    tick();
    in_data_i = 16'h0022;
    tick();
    chk("pre_flush_ready", {31'd0, in_ready_o}, 32'd0);
    flush_i   = 1'b1;
    in_data_i = 16'h000C;
    tick();
    chk("flush2_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush2_data",  {16'd0, out_data_o},  {16'd0, BUB});
    chk("flush2_ready", {31'd0, in_ready_o},  32'd1);
`ifdef PIPE_STAT_EN
    chk("flush2_cnt", {28'd0, flush_cnt_o}, 32'd1);
`endif
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("post_flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("post_flush_data",  {16'd0, out_data_o},  {16'd0, BUB});

    // Flush while ONE: offered payload is swallowed
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0031;
    tick();
    flush_i   = 1'b1;
    in_data_i = 16'h0032;
    tick();
    chk("flush1_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush1_data",  {16'd0, out_data_o},  {16'd0, BUB});
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    tick();
    chk("flush1_after", {31'd0, out_valid_o}, 32'd0);

    // Flush while EMPTY: no count
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flushE_data", {16'd0, out_data_o}, {16'd0, BUB});
`ifdef PIPE_STAT_EN
    chk("flushE_cnt", {28'd0, flush_cnt_o}, 32'd2);
    chk("flushE_stall", {28'd0, stall_cnt_o}, 32'd5);
`endif

    // Asynchronous reset mid-transfer (state ONE holding 0x51)
    in_valid_i = 1'b1;
    in_data_i  = 16'h0051;
    tick();
    in_valid_i = 1'b0;
    chk("pre_rst_data", {16'd0, out_data_o}, 32'h0051);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst_data",  {16'd0, out_data_o},  {16'd0, BUB});
    chk("arst_ready", {31'd0, in_ready_o},  32'd1);
`ifdef PIPE_STAT_EN
    chk("arst_stall", {28'd0, stall_cnt_o}, 32'd0);
    chk("arst_flush", {28'd0, flush_cnt_o}, 32'd0);
`endif
    #2 rst_i = 1'b1;

    // Long stall: output held; counter saturates
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0041;
    tick();
    in_valid_i = 1'b0;
    repeat (15) tick();
`ifdef PIPE_STAT_EN
    chk("stall15", {28'd0, stall_cnt_o}, 32'd15);
`endif
    repeat (5) tick();
    chk("stall_hold_data",  {16'd0, out_data_o},  32'h0041);
    chk("stall_hold_valid", {31'd0, out_valid_o}, 32'd1);
`ifdef PIPE_STAT_EN
    chk("stall_sat", {28'd0, stall_cnt_o}, 32'd15);
`endif
    out_ready_i = 1'b1;
    tick();
    chk("stall_drain", {31'd0, out_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_stage_buf

`default_nettype wire
